ysyx_22040895_mdu: RTL and testbench
====================================

Name: ysyx_22040895_mdu

Overview:
Multi-cycle RV64M multiply/divide unit, directly downstream of the operand-select stage. It consumes opnum1/opnum2 (rs1 value, and rs2-or-immediate) plus an M-extension op code, iterates radix-2 (one bit per cycle), and returns a 64-bit result to writeback. Both sides use valid/ready handshakes so the core can stall on it. It supports flush on pipeline redirect.

Parameters:
XLEN, 64, datapath width; equals the RegBus width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands and op are valid
in_ready  out  1  unit can accept (high only in IDLE)
op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
word  in  1  RV64 *W variant (MULW/DIVW/DIVUW/REMW/REMUW)
opnum1  in  XLEN  operand A (rs1)
opnum2  in  XLEN  operand B (rs2)
flush  in  1  abort current operation, return to IDLE
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  XLEN  final result

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high. On `rst`: state=IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. If in_valid, operands, op and word are latched (fire cycle T).
  - Special case (divide op and divisor==0, or signed-div overflow): go straight to DONE. out_valid=1 at T+1.
  - Otherwise go to CALC with counter=N-1. N=64, or 32 when word=1.
- CALC: one iteration per cycle. Counter decrements; on counter==0 go to DONE. out_valid=1 at T+N+1 (T+65 for 64-bit, T+33 for word). in_ready=0.
- DONE: out_valid=1 and result held stable until out_valid&out_ready. Then go to IDLE with in_ready=1 in the next cycle. There is no same-cycle accept/issue overlap.
- Multiply: shift-add on magnitudes with a 2*XLEN product. Sign is fixed up at the end.
  - MUL low half.
  - MULH signed×signed high.
  - MULHSU signed(A)×unsigned(B) high.
  - MULHU unsigned high.
- Divide: restoring division on magnitudes. Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- word=1:
  - Operands use the low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops) to the 32-bit working width.
  - The 32-bit result is sign-extended to 64 bits, for unsigned variants too.
  - word=1 with op=MULH/MULHSU/MULHU is executed as MULW.
- Divide by zero: quotient = all ones (-1), remainder = dividend. For word ops these use the 32-bit values, then sign-extend.
- Signed overflow (A = most-negative, B = -1, at the active width): quotient = A, remainder = 0.
- flush: takes priority over every other event except rst.
  - In any state, next cycle state=IDLE and out_valid=0. The pending result is discarded.
  - flush together with in_valid in IDLE: the request is not accepted.
- rst mid-operation: same as the reset values, whatever the state.
- Inputs are not sampled outside the fire cycle. opnum1/opnum2 may change freely during CALC.

Test Plan:
- Reset then MUL A=3, B=-5 (0xFFFFFFFFFFFFFFFB) -> out_valid exactly 65 cycles after fire, result 0xFFFFFFFFFFFFFFF1. in_ready=0 during CALC.
- MULHU A=B=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE. MULH same operands -> 0x0000000000000000. MULHSU A=-1, B=2 -> 0xFFFFFFFFFFFFFFFF.
- DIV A=-7, B=2 -> result -3 (0xFFFFFFFFFFFFFFFD). REM A=-7, B=2 -> 0xFFFFFFFFFFFFFFFF. Each with 65-cycle latency.
- DIVU A=100, B=0 -> 0xFFFFFFFFFFFFFFFF, out_valid at T+1. REMU same -> 100. DIV A=0x8000000000000000, B=-1 -> 0x8000000000000000, T+1. REM same -> 0.
- Word ops:
  - DIVW A=0x00000000_80000000, B=0xFFFFFFFF -> 0xFFFFFFFF80000000.
  - REMUW A=0x1_0000000A, B=3 -> 0x0000000000000001, 33-cycle latency.
  - MULW A=0x7FFFFFFF, B=2 -> 0xFFFFFFFFFFFFFFFE.
- Backpressure and abort:
  - Hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next cycle.
  - Assert flush at CALC cycle 20 -> out_valid never rises, in_ready=1 next cycle.
  - Assert rst at CALC cycle 5 -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/ysyx_22040895_mdu.sv
// RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with a sign fix-up on the last iteration and valid/ready on both sides.
module ysyx_22040895_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] opnum1,
    input  logic [XLEN-1:0] opnum2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_word, r_negq, r_negr;
    logic [XLEN-1:0] r_hi, r_lo, r_opb, r_result;
    logic            r_in_ready, r_out_valid;

    logic            w_is_div, w_sa, w_sb, w_a_neg, w_b_neg, w_div0, w_ovf;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_raw, w_spec;

    // Fire-cycle decode: operand extension, magnitudes and the early-exit divide cases.
    always_comb begin
        w_is_div = op[2];
        if (w_is_div) begin
            w_sa = ~op[0];
            w_sb = ~op[0];
        end else if (word) begin
            w_sa = 1'b1;
            w_sb = 1'b1;
        end else begin
            w_sa = (op[1:0] != 2'b11);
            w_sb = ~op[1];
        end
        if (word) begin
            w_a_ext = {{HW{w_sa & opnum1[HW-1]}}, opnum1[HW-1:0]};
            w_b_ext = {{HW{w_sb & opnum2[HW-1]}}, opnum2[HW-1:0]};
            w_a_raw = {{HW{opnum1[HW-1]}}, opnum1[HW-1:0]};
            w_ovf   = (opnum1[HW-1:0] == {1'b1, {(HW-1){1'b0}}});
        end else begin
            w_a_ext = opnum1;
            w_b_ext = opnum2;
            w_a_raw = opnum1;
            w_ovf   = (opnum1 == {1'b1, {(XLEN-1){1'b0}}});
        end
        w_a_neg = w_sa & w_a_ext[XLEN-1];
        w_b_neg = w_sb & w_b_ext[XLEN-1];
        w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;
        w_div0  = (w_b_ext == '0);
        w_ovf   = w_ovf & ~op[0] & (w_b_ext == '1);
        if (op[1])
            w_spec = w_div0 ? w_a_raw : '0;
        else
            w_spec = w_div0 ? '1 : w_a_raw;
    end

    logic [XLEN:0]     w_sum, w_rs;
    logic              w_ge;
    logic [XLEN-1:0]   w_hi_nx, w_lo_nx;
    logic [2*XLEN-1:0] w_mabs, w_mres;
    logic [XLEN-1:0]   w_qabs, w_rabs, w_qres, w_rres, w_raw, w_res;

    // Word ops run HW iterations, so the product lands at bits [XLEN+HW-1:HW] of {hi,lo};
    // word dividends are pre-shifted so the divide always shifts out of lo's MSB.
    always_comb begin
        w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_rs  = {r_hi, r_lo[XLEN-1]};
        w_ge  = (w_rs >= {1'b0, r_opb});
        if (r_op[2]) begin
            w_hi_nx = w_ge ? (w_rs[XLEN-1:0] - r_opb) : w_rs[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_mabs = r_word ? {{XLEN{1'b0}}, w_hi_nx[HW-1:0], w_lo_nx[XLEN-1:HW]} : {w_hi_nx, w_lo_nx};
        w_mres = r_negq ? -w_mabs : w_mabs;
        w_qabs = r_word ? {{HW{1'b0}}, w_lo_nx[HW-1:0]} : w_lo_nx;
        w_rabs = r_word ? {{HW{1'b0}}, w_hi_nx[HW-1:0]} : w_hi_nx;
        w_qres = r_negq ? -w_qabs : w_qabs;
        w_rres = r_negr ? -w_rabs : w_rabs;
        if (!r_op[2])
            w_raw = (r_word || r_op[1:0] == 2'b00) ? w_mres[XLEN-1:0] : w_mres[2*XLEN-1:XLEN];
        else
            w_raw = r_op[1] ? w_rres : w_qres;
        w_res = r_word ? {{HW{w_raw[HW-1]}}, w_raw[HW-1:0]} : w_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_word      <= 1'b0;
            r_negq      <= 1'b0;
            r_negr      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opb       <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_word     <= word;
                        r_negq     <= w_a_neg ^ w_b_neg;
                        r_negr     <= w_a_neg;
                        r_hi       <= '0;
                        r_in_ready <= 1'b0;
                        r_cnt      <= word ? CW'(HW - 1) : CW'(XLEN - 1);
                        if (w_is_div) begin
                            r_lo  <= word ? {w_a_mag[HW-1:0], {HW{1'b0}}} : w_a_mag;
                            r_opb <= w_b_mag;
                        end else begin
                            r_lo  <= w_b_mag;
                            r_opb <= w_a_mag;
                        end
                        if (w_is_div && (w_div0 || w_ovf)) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_spec;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_hi <= w_hi_nx;
                    r_lo <= w_lo_nx;
                    if (r_cnt == '0) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_res;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

// File: tb/tb_ysyx_22040895_mdu.sv
// Bench for ysyx_22040895_mdu: directed vector table, handshake/abort sequences,
// and randomized operations checked against a plain-arithmetic RV64M model.
module tb_ysyx_22040895_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic        word = 1'b0;
    logic [63:0] opnum1 = '0;
    logic [63:0] opnum2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22040895_mdu #(.XLEN(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .word     (word),
        .opnum1   (opnum1),
        .opnum2   (opnum2),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic [7:0]  lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV64M rules.
    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  r32;
        logic [63:0]  r;
        longint       sa, sb;
        int           wa, wb;
        if (w) begin
            wa = a[31:0];
            wb = b[31:0];
            if (!o[2])                 r32 = wa * wb;
            else if (b[31:0] == 32'd0) r32 = o[1] ? a[31:0] : 32'hFFFF_FFFF;
            else if (!o[0]) begin
                if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    r32 = o[1] ? 32'd0 : a[31:0];
                else
                    r32 = o[1] ? wa % wb : wa / wb;
            end else
                r32 = o[1] ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
            return {{32{r32[31]}}, r32};
        end
        sa = a;
        sb = b;
        case (o)
            3'd0: r = a * b;
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
            default: begin
                if (b == 64'd0)
                    r = o[1] ? a : '1;
                else if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1)
                    r = o[1] ? 64'd0 : a;
                else if (!o[0])
                    r = o[1] ? sa % sb : sa / sb;
                else
                    r = o[1] ? a % b : a / b;
            end
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = !o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (o[2] && (zero || ovf)) return 1;
        return w ? 33 : 65;
    endfunction

    task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("issue_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op = o;
        word = w;
        opnum1 = a;
        opnum2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opnum1 = {$urandom, $urandom};
        opnum2 = {$urandom, $urandom};
    endtask

    task automatic wait_valid(output logic [63:0] res, output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 200);
        res = result;
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        logic [63:0] res;
        int          lat;
        logic        busy_ok;
        issue(o, w, a, b);
        wait_valid(res, lat, busy_ok);
        check({tag, "_result"}, res, exp);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        accept(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 1000000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[16];
        logic [63:0] res0, res;
        logic [63:0] a, b;
        logic [2:0]  o;
        logic        w;
        int          lat;
        logic        busy_ok, seen, stable, rdy_low;

        vecs[0]  = '{3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 8'd65};
        vecs[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 8'd65};
        vecs[2]  = '{3'd1, 1'b0, '1, '1, 64'd0, 8'd65};
        vecs[3]  = '{3'd2, 1'b0, '1, 64'd2, '1, 8'd65};
        vecs[4]  = '{3'd4, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd65};
        vecs[5]  = '{3'd6, 1'b0, -64'sd7, 64'd2, '1, 8'd65};
        vecs[6]  = '{3'd5, 1'b0, 64'd100, 64'd0, '1, 8'd1};
        vecs[7]  = '{3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 8'd1};
        vecs[8]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 8'd1};
        vecs[9]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 8'd1};
        vecs[10] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8'd1};
        vecs[11] = '{3'd7, 1'b1, 64'h0000_0001_0000_000A, 64'd3, 64'd1, 8'd33};
        vecs[12] = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8'd33};
        vecs[13] = '{3'd4, 1'b1, 64'h1234_5678_8765_4321, 64'hABCD_0000_0000_0000, '1, 8'd1};
        vecs[14] = '{3'd6, 1'b1, 64'h1234_5678_8765_4321, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8765_4321, 8'd1};
        vecs[15] = '{3'd1, 1'b1, 64'hFFFF_FFFF_0000_0003, 64'd5, 64'd15, 8'd33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", result, 64'd0);

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
                   vecs[i].exp, int'(vecs[i].lat));

        // Backpressure: result must hold while out_ready stays low.
        issue(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        wait_valid(res0, lat, busy_ok);
        check("bp_result", res0, 64'hFFFF_FFFF_FFFF_FFF1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || result !== res0) stable = 1'b0;
        end
        check("bp_hold_stable", {63'd0, stable}, 64'd1);
        accept("bp");

        // Flush in the 20th CALC cycle.
        issue(3'd4, 1'b0, -64'sd7, 64'd2);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", {63'd0, seen}, 64'd0);

        // Flush together with in_valid in IDLE: request is dropped.
        @(negedge clk);
        in_valid = 1'b1;
        flush = 1'b1;
        op = 3'd5;
        word = 1'b0;
        opnum1 = 64'd9;
        opnum2 = 64'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        seen = 1'b0;
        rdy_low = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            if (!in_ready) rdy_low = 1'b1;
        end
        check("flush_issue_no_valid", {63'd0, seen}, 64'd0);
        check("flush_issue_not_taken", {63'd0, rdy_low}, 64'd0);

        // Reset in the 5th CALC cycle.
        issue(3'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_result", result, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", {63'd0, seen}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = w ? {b[63:32], 32'd0} : 64'd0;
                1: begin
                    a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
                end
                2: begin
                    a = 64'($signed(8'($urandom)));
                    b = 64'($signed(8'($urandom)));
                end
                default: ;
            endcase
            issue(o, w, a, b);
            wait_valid(res, lat, busy_ok);
            check($sformatf("rand%0d_op%0d_w%0d_result", i, o, w), res, model(o, w, a, b));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(model_lat(o, w, a, b)));
            check($sformatf("rand%0d_busy", i), {63'd0, busy_ok}, 64'd1);
            accept($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
